// File: rtl/uart_transmitter.sv
// UART transmit path: start bit, LSB-first data, optional even parity, stop bits.
// Bit timing comes from a 16x oversampling NCO that matches the receiver's step formula.
module uart_transmitter #(
  parameter int EIGHT_BIT_DATA = 8,
  parameter int PARITY_BIT     = 0,
  parameter int STOP_BIT       = 2,
  parameter int DEFAULT_BDR    = 115200,
  parameter int SYS_CLK        = 100_000_000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [EIGHT_BIT_DATA-1:0] data,
  input  logic                      start,
  output logic                      txd,
  output logic                      busy,
  output logic                      done,
  output logic [2:0]                dbg_state
);

  localparam logic [63:0] STEP_FULL =
    (64'd16 * 64'(DEFAULT_BDR) * 64'd65536) / 64'(SYS_CLK);
  localparam logic [15:0] STEP      = STEP_FULL[15:0];
  localparam logic [2:0]  LAST_BIT  = 3'(EIGHT_BIT_DATA - 1);
  localparam logic [1:0]  LAST_STOP = 2'(STOP_BIT - 1);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    START_BIT   = 3'd1,
    SEND_DATA   = 3'd2,
    SEND_PARITY = 3'd3,
    SEND_STOP   = 3'd4,
    DONE        = 3'd5
  } state_t;

  state_t                    state, state_nx;
  logic [EIGHT_BIT_DATA-1:0] shreg, shreg_nx;
  logic                      parity, parity_nx;
  logic [15:0]               acc, acc_nx;
  logic [3:0]                tick_cnt, tick_nx;
  logic [2:0]                bit_cnt, bit_nx;
  logic [1:0]                stop_cnt, stop_nx;
  logic                      txd_nx, busy_nx, done_nx;
  logic [16:0]               sum;
  logic                      tick, bit_end, accept;

  assign sum     = {1'b0, acc} + {1'b0, STEP};
  assign tick    = sum[16];
  assign bit_end = tick && (tick_cnt == 4'hf);
  // The DONE exit edge doubles as an accept edge so a held start gives back-to-back frames.
  assign accept  = start && ((state == IDLE) || (state == DONE));
  assign dbg_state = state;

  always_comb begin
    state_nx  = state;
    shreg_nx  = shreg;
    parity_nx = parity;
    acc_nx    = sum[15:0];
    tick_nx   = tick ? tick_cnt + 4'd1 : tick_cnt;
    bit_nx    = bit_cnt;
    stop_nx   = stop_cnt;
    txd_nx    = txd;
    busy_nx   = busy;
    done_nx   = 1'b0;
    case (state)
      IDLE: begin
        txd_nx  = 1'b1;
        busy_nx = 1'b0;
      end
      START_BIT: begin
        if (bit_end) begin
          state_nx = SEND_DATA;
          txd_nx   = shreg[0];
          shreg_nx = {1'b0, shreg[EIGHT_BIT_DATA-1:1]};
          bit_nx   = 3'd0;
        end
      end
      SEND_DATA: begin
        if (bit_end) begin
          if (bit_cnt == LAST_BIT) begin
            stop_nx = 2'd0;
            if (PARITY_BIT != 0) begin
              state_nx = SEND_PARITY;
              txd_nx   = parity;
            end else begin
              state_nx = SEND_STOP;
              txd_nx   = 1'b1;
            end
          end else begin
            bit_nx   = bit_cnt + 3'd1;
            txd_nx   = shreg[0];
            shreg_nx = {1'b0, shreg[EIGHT_BIT_DATA-1:1]};
          end
        end
      end
      SEND_PARITY: begin
        if (bit_end) begin
          state_nx = SEND_STOP;
          txd_nx   = 1'b1;
          stop_nx  = 2'd0;
        end
      end
      SEND_STOP: begin
        if (bit_end) begin
          if (stop_cnt == LAST_STOP) begin
            state_nx = DONE;
            done_nx  = 1'b1;
          end else begin
            stop_nx = stop_cnt + 2'd1;
          end
        end
      end
      DONE: begin
        state_nx = IDLE;
        txd_nx   = 1'b1;
        busy_nx  = 1'b0;
      end
      default: state_nx = IDLE;
    endcase
    if (accept) begin
      state_nx  = START_BIT;
      shreg_nx  = data;
      parity_nx = ^data;
      acc_nx    = 16'd0;
      tick_nx   = 4'd0;
      bit_nx    = 3'd0;
      stop_nx   = 2'd0;
      txd_nx    = 1'b0;
      busy_nx   = 1'b1;
      done_nx   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      parity   <= 1'b0;
      acc      <= 16'd0;
      tick_cnt <= 4'd0;
      bit_cnt  <= 3'd0;
      stop_cnt <= 2'd0;
      txd      <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      shreg    <= shreg_nx;
      parity   <= parity_nx;
      acc      <= acc_nx;
      tick_cnt <= tick_nx;
      bit_cnt  <= bit_nx;
      stop_cnt <= stop_nx;
      txd      <= txd_nx;
      busy     <= busy_nx;
      done     <= done_nx;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: three configurations checked cycle by cycle against
// a frame model built from bit lists and the NCO carry-count arithmetic.
module tb_uart_transmitter;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_r;
  logic [7:0] data_r;
  int         sel;
  int         vectors = 0;
  int         errors  = 0;

  logic       txd_a, busy_a, done_a, txd_b, busy_b, done_b, txd_c, busy_c, done_c;
  logic [2:0] dbg_a, dbg_b, dbg_c;
  logic       start_a, start_b, start_c, txd_s, busy_s, done_s;

  always #5 clk = ~clk;

  assign start_a = start_r && (sel == 0);
  assign start_b = start_r && (sel == 1);
  assign start_c = start_r && (sel == 2);
  assign txd_s   = (sel == 0) ? txd_a  : (sel == 1) ? txd_b  : txd_c;
  assign busy_s  = (sel == 0) ? busy_a : (sel == 1) ? busy_b : busy_c;
  assign done_s  = (sel == 0) ? done_a : (sel == 1) ? done_b : done_c;

  uart_transmitter #(.EIGHT_BIT_DATA(8), .PARITY_BIT(0), .STOP_BIT(2),
                     .DEFAULT_BDR(4096), .SYS_CLK(1_048_576)) dut_a (
    .clk(clk), .rst(rst), .data(data_r), .start(start_a),
    .txd(txd_a), .busy(busy_a), .done(done_a), .dbg_state(dbg_a));

  uart_transmitter #(.EIGHT_BIT_DATA(8), .PARITY_BIT(1), .STOP_BIT(1),
                     .DEFAULT_BDR(4096), .SYS_CLK(1_048_576)) dut_b (
    .clk(clk), .rst(rst), .data(data_r), .start(start_b),
    .txd(txd_b), .busy(busy_b), .done(done_b), .dbg_state(dbg_b));

  uart_transmitter dut_c (
    .clk(clk), .rst(rst), .data(data_r), .start(start_c),
    .txd(txd_c), .busy(busy_c), .done(done_c), .dbg_state(dbg_c));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Edge (clocks after accept) at which the NCO has produced 16*n carries.
  function automatic longint bound(input int n, input int step);
    return (longint'(n) * 16 * 65536 + step - 1) / step;
  endfunction

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    data_r  = d;
    start_r = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Called #1 after the accept edge; checks every cycle through the end of frame.
  task automatic check_frame(input logic [7:0] d, input int par, input int stops,
                             input int step, input bit hold, input logic [7:0] next_d,
                             input int abort_m);
    logic       exp_bits[$];
    int         nb, idx;
    longint     bn, done_at;
    logic [7:0] rx;
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
    if (par != 0) exp_bits.push_back(^d);
    for (int i = 0; i < stops; i++) exp_bits.push_back(1'b1);
    nb = exp_bits.size();
    bn = bound(nb, step);
    idx = 0;
    rx = 8'h00;
    done_at = -1;
    for (longint m = 0; m <= bn; m++) begin
      while (idx < nb && bound(idx + 1, step) <= m) idx++;
      if (m == abort_m) begin
        rst = 1'b1;
        #1;
        check_eq("abort_txd", txd_s, 1);
        check_eq("abort_busy", busy_s, 0);
        check_eq("abort_done", done_s, 0);
        repeat (3) begin
          @(posedge clk); #1;
          check_eq("rst_hold_done", done_s, 0);
          check_eq("rst_hold_txd", txd_s, 1);
        end
        @(negedge clk);
        rst = 1'b0;
        start_r = 1'b0;
        return;
      end
      check_eq($sformatf("txd@%0d", m), txd_s, (idx < nb) ? exp_bits[idx] : 1'b1);
      check_eq($sformatf("busy@%0d", m), busy_s, 1);
      check_eq($sformatf("done@%0d", m), done_s, (m == bn) ? 1 : 0);
      if (done_s && done_at < 0) done_at = m;
      if (idx >= 1 && idx <= 8 &&
          m == (bound(idx, step) + bound(idx + 1, step)) / 2)
        rx[idx-1] = txd_s;
      if (m == 5) data_r = next_d;
      if (!hold) start_r = (m == 1000 || m == bn - 1);
      @(posedge clk);
      #1;
    end
    check_eq("frame_len", 32'(done_at), 32'(bn));
    check_eq("loopback", rx, d);
    if (!hold) begin
      check_eq("idle_busy", busy_s, 0);
      check_eq("idle_txd", txd_s, 1);
      check_eq("idle_done", done_s, 0);
    end
  endtask

  initial begin
    int         step_c;
    logic [7:0] rnd;
    rst = 1'b1;
    start_r = 1'b0;
    data_r = 8'h00;
    sel = 0;
    step_c = int'((64'd16 * 64'd115200 * 64'd65536) / 64'd100_000_000);
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check_eq("rst_txd", txd_s, 1);
      check_eq("rst_busy", busy_s, 0);
      check_eq("rst_done", done_s, 0);
    end
    @(negedge clk);
    rst = 1'b0;

    sel = 0;
    send(8'hA5);
    check_frame(8'hA5, 0, 2, 4096, 1'b0, 8'h5A, -1);
    rnd = 8'($urandom_range(0, 255));
    send(rnd);
    check_frame(rnd, 0, 2, 4096, 1'b0, ~rnd, 1000);
    rnd = 8'($urandom_range(0, 255));
    send(rnd);
    check_frame(rnd, 0, 2, 4096, 1'b0, ~rnd, -1);
    send(8'h00);
    check_frame(8'h00, 0, 2, 4096, 1'b1, 8'hFF, -1);
    check_frame(8'hFF, 0, 2, 4096, 1'b0, 8'h00, -1);

    sel = 1;
    send(8'h07);
    check_frame(8'h07, 1, 1, 4096, 1'b0, 8'hF8, -1);
    send(8'h03);
    check_frame(8'h03, 1, 1, 4096, 1'b0, 8'hFC, -1);
    rnd = 8'($urandom_range(0, 255));
    send(rnd);
    check_frame(rnd, 1, 1, 4096, 1'b0, ~rnd, -1);

    sel = 2;
    send(8'h3C);
    check_frame(8'h3C, 0, 2, step_c, 1'b0, 8'hC3, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
